// File: rtl/counter_capture_pkg.sv
// Shared definitions for the event timestamp capture block: edge-select encodings
// and the post-reset arming interval.
package counter_capture_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;

  // Detect cycles ignored after reset release while the synchronizer fills.
  localparam int unsigned ARM_CYCLES = 3;

  function automatic logic edge_match(input edge_sel_e sel, input logic rise, input logic fall);
    logic m;
    m = 1'b0;
    case (sel)
      EDGE_RISE: m = rise;
      EDGE_FALL: m = fall;
      EDGE_BOTH: m = rise | fall;
      default:   m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; read data comes from the head slot
// so a written entry is visible on the cycle after the write (no fall-through).
module sync_fifo
  import counter_capture_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     a_rst_n_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/counter_capture.sv
// Free-running timestamp counter that records the count at each selected edge of an
// asynchronous event line, together with a flag marking a counter wrap since the last record.
module counter_capture
  import counter_capture_pkg::*;
#(
  parameter int COUNTER_WIDTH = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk_i,
  input  logic                          a_rst_n_i,
  input  logic                          enable_i,
  input  logic                          clear_i,
  input  logic                          event_i,
  input  logic [1:0]                    edge_sel_i,
  output logic                          ts_valid_o,
  input  logic                          ts_ready_i,
  output logic [COUNTER_WIDTH-1:0]      ts_data_o,
  output logic                          ts_wrap_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int RW = COUNTER_WIDTH + 1;

  logic                     evt_p0;
  logic                     evt_p1;
  logic                     evt_p2;
  logic [1:0]               arm_q;
  logic                     armed;
  logic                     rise;
  logic                     fall;
  logic                     capture;
  logic [COUNTER_WIDTH-1:0] cnt_q;
  logic                     wrap;
  logic                     wrap_pending_q;
  logic                     overflow_q;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     drop;
  logic [RW-1:0]            fifo_rdata;

  // Stage boundary: event_i -> evt_p0/evt_p1 synchronizer -> evt_p2 history for edge detect.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      evt_p0 <= 1'b0;
      evt_p1 <= 1'b0;
      evt_p2 <= 1'b0;
      arm_q  <= '0;
    end else begin
      evt_p0 <= event_i;
      evt_p1 <= evt_p0;
      evt_p2 <= evt_p1;
      if (!armed) arm_q <= arm_q + 2'd1;
    end
  end

  assign armed   = (arm_q == 2'(ARM_CYCLES));
  assign rise    = evt_p1 & ~evt_p2;
  assign fall    = ~evt_p1 & evt_p2;
  assign capture = edge_match(edge_sel_e'(edge_sel_i), rise, fall) && armed && enable_i && !clear_i;

  assign wrap      = enable_i && (&cnt_q);
  assign fifo_pop  = ts_valid_o && ts_ready_i && !clear_i;
  assign fifo_push = capture && (!fifo_full || fifo_pop);
  assign drop      = capture && fifo_full && !fifo_pop;

  // Stage boundary: detect cycle -> record pushed with the count seen in that cycle.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      cnt_q          <= '0;
      wrap_pending_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else if (clear_i) begin
      cnt_q          <= '0;
      wrap_pending_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      if (enable_i) cnt_q <= cnt_q + COUNTER_WIDTH'(1);
      // A wrap coinciding with a push belongs to the next record.
      if (wrap)           wrap_pending_q <= 1'b1;
      else if (fifo_push) wrap_pending_q <= 1'b0;
      if (drop) overflow_q <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .a_rst_n_i (a_rst_n_i),
    .clear_i   (clear_i),
    .push_i    (fifo_push),
    .wdata_i   ({wrap_pending_q, cnt_q}),
    .pop_i     (fifo_pop),
    .rdata_o   (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level_o)
  );

  assign ts_valid_o              = !fifo_empty;
  assign {ts_wrap_o, ts_data_o}  = fifo_rdata;
  assign overflow_o              = overflow_q;

endmodule

// File: tb/tb_counter_capture.sv
// Bench for counter_capture: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the capture rules.
module tb_counter_capture;

  localparam int CW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = 3;
  localparam int MASK  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          clr;
  logic          ev;
  logic [1:0]    sel;
  logic          rdy;
  logic          ts_valid;
  logic [CW-1:0] ts_data;
  logic          ts_wrap;
  logic          ovf;
  logic [LW-1:0] level;

  always #5 clk = ~clk;

  counter_capture #(
    .COUNTER_WIDTH (CW),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk_i      (clk),
    .a_rst_n_i  (rst_n),
    .enable_i   (en),
    .clear_i    (clr),
    .event_i    (ev),
    .edge_sel_i (sel),
    .ts_valid_o (ts_valid),
    .ts_ready_i (rdy),
    .ts_data_o  (ts_data),
    .ts_wrap_o  (ts_wrap),
    .overflow_o (ovf),
    .level_o    (level)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: event samples per clock, record queue, counter and flags.
  int m_cnt;
  bit m_wrap;
  bit m_ovf;
  int m_q[$];
  bit ev_hist[$];
  int m_k;

  function automatic bit ev_at(input int n);
    if (n >= 1 && n <= ev_hist.size()) return ev_hist[n-1];
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_wrap = 0;
    m_ovf  = 0;
    m_q.delete();
    ev_hist.delete();
    m_k = 0;
  endtask

  task automatic model_step();
    bit newer, older, rise, fall, match, cap, pop, full, pushed, wrapped;
    newer = ev_at(m_k - 1);
    older = ev_at(m_k - 2);
    rise  = newer && !older;
    fall  = !newer && older;
    match = (sel == 2'd1 && rise) || (sel == 2'd2 && fall) || (sel == 2'd3 && (rise || fall));
    cap   = match && (m_k >= 3) && en && !clr;
    pop   = (m_q.size() != 0) && rdy && !clr;
    if (clr) begin
      m_cnt  = 0;
      m_wrap = 0;
      m_ovf  = 0;
      m_q.delete();
    end else begin
      full   = (m_q.size() == DEPTH);
      pushed = 0;
      if (pop) void'(m_q.pop_front());
      if (cap) begin
        if (full && !pop) m_ovf = 1;
        else begin
          m_q.push_back((int'(m_wrap) << CW) | m_cnt);
          pushed = 1;
        end
      end
      wrapped = en && (m_cnt == MASK);
      if (wrapped)     m_wrap = 1;
      else if (pushed) m_wrap = 0;
      if (en) m_cnt = (m_cnt + 1) & MASK;
    end
    ev_hist.push_back(ev);
    m_k++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_eq("valid", ts_valid, m_q.size() != 0);
    check_eq("level", level, m_q.size());
    check_eq("overflow", ovf, m_ovf);
    if (m_q.size() != 0) begin
      check_eq("ts_data", ts_data, m_q[0] & MASK);
      check_eq("ts_wrap", ts_wrap, (m_q[0] >> CW) & 1);
    end
  endtask

  task automatic run_to(input int target);
    repeat ((target - m_cnt) & MASK) cycle();
  endtask

  // One-cycle pulse; the record is pushed on the third clock, optionally with a pop there.
  task automatic fire(input bit pop_on_push, output int ts);
    ts  = (m_cnt + 2) & MASK;
    ev  = 1'b1;
    cycle();
    ev  = 1'b0;
    cycle();
    if (pop_on_push) rdy = 1'b1;
    cycle();
    rdy = 1'b0;
    cycle();
  endtask

  task automatic do_clear();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
  endtask

  task automatic drain();
    rdy = 1'b1;
    repeat (DEPTH + 1) cycle();
    rdy = 1'b0;
  endtask

  initial begin
    int t;
    int ts_exp[DEPTH];
    int c;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; ev = 1'b0; sel = 2'd0; rdy = 1'b0;
    model_reset();
    #1;
    check_eq("rst_valid", ts_valid, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_ovf", ovf, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) cycle();

    // Basic rising capture from count 0x10.
    do_clear();
    en = 1'b1; sel = 2'd1;
    repeat (16) cycle();
    ev = 1'b1;
    repeat (3) cycle();
    check_eq("basic_level", level, 1);
    check_eq("basic_ts", ts_data, 'h12);
    check_eq("basic_wrap", ts_wrap, 0);
    ev = 1'b0;
    repeat (3) cycle();
    drain();

    // Wrap flag across 0xFF -> 0x00.
    do_clear();
    run_to('hFC); fire(0, t);
    run_to('h01); fire(0, t);
    run_to('h0E); fire(0, t);
    check_eq("wrap_level", level, 3);
    check_eq("wrap_ts0", ts_data, 'hFE);
    check_eq("wrap_w0", ts_wrap, 0);
    rdy = 1'b1; cycle(); rdy = 1'b0;
    check_eq("wrap_ts1", ts_data, 'h03);
    check_eq("wrap_w1", ts_wrap, 1);
    rdy = 1'b1; cycle(); rdy = 1'b0;
    check_eq("wrap_ts2", ts_data, 'h10);
    check_eq("wrap_w2", ts_wrap, 0);
    drain();

    // Overflow: five captures into a depth-4 FIFO with no reader.
    do_clear();
    for (int i = 0; i < 5; i++) begin
      fire(0, t);
      if (i < DEPTH) ts_exp[i] = t;
    end
    check_eq("ovf_level", level, DEPTH);
    check_eq("ovf_flag", ovf, 1);
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("ovf_order", ts_data, ts_exp[i]);
      rdy = 1'b1; cycle(); rdy = 1'b0;
    end

    // Full FIFO with a pop in the capture cycle.
    do_clear();
    repeat (DEPTH) fire(0, t);
    fire(1, t);
    check_eq("fullpop_ovf", ovf, 0);
    check_eq("fullpop_level", level, DEPTH);
    drain();

    // Both edges of a 3-cycle pulse, with the reader stalled.
    do_clear();
    sel = 2'd3;
    c = m_cnt;
    ev = 1'b1;
    repeat (3) cycle();
    ev = 1'b0;
    repeat (4) cycle();
    check_eq("both_level", level, 2);
    check_eq("both_rise", ts_data, (c + 2) & MASK);
    repeat (2) cycle();
    check_eq("both_hold", ts_data, (c + 2) & MASK);
    rdy = 1'b1; cycle(); rdy = 1'b0;
    check_eq("both_fall", ts_data, (c + 5) & MASK);
    drain();

    // Asynchronous reset with records pending, event high through release.
    sel = 2'd1;
    do_clear();
    repeat (2) fire(0, t);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", ts_valid, 0);
    check_eq("arst_level", level, 0);
    model_reset();
    ev = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (8) cycle();
    check_eq("arst_nocap", level, 0);
    ev = 1'b0;
    repeat (3) cycle();

    // Clear while overflow is set; counter restarts from zero.
    repeat (DEPTH + 1) fire(0, t);
    check_eq("clr_ovf_pre", ovf, 1);
    do_clear();
    check_eq("clr_ovf", ovf, 0);
    check_eq("clr_level", level, 0);
    fire(0, t);
    check_eq("clr_cnt", ts_data, 2);
    drain();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(15) != 0);
      clr = ($urandom_range(127) == 0);
      if ($urandom_range(31) == 0) sel = 2'($urandom_range(3));
      if ($urandom_range(2) == 0) ev = ~ev;
      rdy = (i < 1500) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
